// File: rtl/stage_wb_pkg.sv
// stage_wb shared definitions.
// Writeback source codes, load width codes and a width helper.
package stage_wb_pkg;

    localparam int REG_WIDTH_DEF      = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } ld_size_e;

    // Access size of a load; unknown width codes behave as a word load.
    function automatic ld_size_e ld_size(input logic [2:0] f3);
        ld_size_e sz;
        sz = SZ_WORD;
        if (f3 == F3_LB || f3 == F3_LBU)
            sz = SZ_BYTE;
        else if (f3 == F3_LH || f3 == F3_LHU)
            sz = SZ_HALF;
        return sz;
    endfunction

endpackage

// File: rtl/stage_wb_load_align.sv
// Load data alignment and extension.
// Picks the addressed byte/half out of the DMEM word and flags misalignment.
module stage_wb_load_align
    import stage_wb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] word,
    input  logic [1:0]   off,
    input  logic [2:0]   funct3,
    output logic [W-1:0] data,
    output logic         misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sgn;

    assign byte_v = word[{off, 3'b000} +: 8];
    assign half_v = word[{off[1], 4'b0000} +: 16];
    assign sgn    = ~funct3[2];

    // Extend the selected lane and check the offset against the access size.
    always_comb begin
        data       = word;
        misaligned = 1'b0;
        unique case (ld_size(funct3))
            SZ_BYTE: begin
                data = {{(W-8){sgn & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                data       = {{(W-16){sgn & half_v[15]}}, half_v};
                misaligned = off[0];
            end
            default: begin
                data       = word;
                misaligned = |off;
            end
        endcase
    end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: load alignment, result mux, MEM/WB register.
// Also keeps the retired-instruction counter.
module stage_wb
    import stage_wb_pkg::*;
#(
    parameter int REG_WIDTH      = REG_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      EX_MEM_valid,
    input  logic                      EX_MEM_reg_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd_addr,
    input  logic [1:0]                EX_MEM_wb_sel,
    input  logic [2:0]                EX_MEM_funct3,
    input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]      EX_MEM_pc_plus4,
    input  logic [REG_WIDTH-1:0]      DMEM_data_out,
    output logic                      WB_reg_write_en,
    output logic [REG_ADDR_WIDTH-1:0] WB_rd_addr,
    output logic [REG_WIDTH-1:0]      WB_rd_data,
    output logic                      WB_load_misaligned,
    output logic [REG_WIDTH-1:0]      WB_instret
);

    localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

    logic [REG_WIDTH-1:0]      ld_data;
    logic                      ld_mis;
    logic                      mis;
    logic                      capture;
    logic                      we_next;
    logic [REG_WIDTH-1:0]      result;

    logic                      wb_we;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [REG_WIDTH-1:0]      wb_data;
    logic                      wb_mis;
    logic [REG_WIDTH-1:0]      instret;

    stage_wb_load_align #(
        .W(REG_WIDTH)
    ) u_align (
        .word      (DMEM_data_out),
        .off       (EX_MEM_alu_out[1:0]),
        .funct3    (EX_MEM_funct3),
        .data      (ld_data),
        .misaligned(ld_mis)
    );

    assign mis     = EX_MEM_valid & (EX_MEM_wb_sel == WB_SEL_LOAD) & ld_mis;
    assign capture = ~flush & ~stall;
    assign we_next = EX_MEM_valid & EX_MEM_reg_write_en
                   & (|EX_MEM_rd_addr) & ~mis;

    // Writeback source select; the reserved code falls back to the ALU.
    always_comb begin
        result = EX_MEM_alu_out;
        unique case (EX_MEM_wb_sel)
            WB_SEL_LOAD: result = ld_data;
            WB_SEL_PC4:  result = EX_MEM_pc_plus4;
            default:     result = EX_MEM_alu_out;
        endcase
    end

    // MEM/WB register: flush beats stall; data fields idle during a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            wb_mis  <= 1'b0;
        end else if (flush) begin
            wb_we   <= 1'b0;
            wb_mis  <= 1'b0;
        end else if (!stall) begin
            wb_we   <= we_next;
            wb_rd   <= EX_MEM_rd_addr;
            wb_data <= result;
            wb_mis  <= mis;
        end
    end

    // Retired count: every captured valid instruction that is not misaligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            instret <= '0;
        else if (capture && EX_MEM_valid && !mis)
            instret <= instret + ONE;
    end

    assign WB_reg_write_en    = wb_we;
    assign WB_rd_addr         = wb_rd;
    assign WB_rd_data         = wb_data;
    assign WB_load_misaligned = wb_mis;
    assign WB_instret         = instret;

endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb.
// Directed cases followed by randomized traffic against a behavioural model.
module tb_stage_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        valid;
    logic        rwe;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] word;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_mis;
    logic [31:0] wb_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_mis;
    logic [31:0] m_cnt;
    logic        m_dc;

    always #5 clk = ~clk;

    stage_wb dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .stall              (stall),
        .flush              (flush),
        .EX_MEM_valid       (valid),
        .EX_MEM_reg_write_en(rwe),
        .EX_MEM_rd_addr     (rd),
        .EX_MEM_wb_sel      (sel),
        .EX_MEM_funct3      (f3),
        .EX_MEM_alu_out     (alu),
        .EX_MEM_pc_plus4    (pc4),
        .DMEM_data_out      (word),
        .WB_reg_write_en    (wb_we),
        .WB_rd_addr         (wb_rd),
        .WB_rd_data         (wb_data),
        .WB_load_misaligned (wb_mis),
        .WB_instret         (wb_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] c,
                                             input logic [31:0] a,
                                             input logic [31:0] w);
        int unsigned o;
        int unsigned v;
        o = a % 4;
        case (c)
            3'b000, 3'b100: begin
                v = (w >> (8 * o)) & 32'hFF;
                if (c == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
            end
            3'b001, 3'b101: begin
                v = (w >> (16 * (o / 2))) & 32'hFFFF;
                if (c == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit ref_mis(input logic [1:0] s, input logic [2:0] c,
                                   input logic [31:0] a);
        int unsigned o;
        o = a % 4;
        if (s != 2'b01) return 1'b0;
        if (c == 3'b000 || c == 3'b100) return 1'b0;
        if (c == 3'b001 || c == 3'b101) return (o % 2) == 1;
        return o != 0;
    endfunction

    task automatic model_reset();
        m_we = 0; m_rd = 0; m_data = 0; m_mis = 0; m_cnt = 0; m_dc = 0;
    endtask

    task automatic model_edge();
        bit mi;
        if (!reset_n) return;
        if (flush) begin
            m_we = 0; m_mis = 0; m_dc = 1;
        end else if (!stall) begin
            mi = valid && ref_mis(sel, f3, alu);
            m_we = valid && rwe && (rd != 0) && !mi;
            m_mis = mi;
            m_rd = rd;
            if (sel == 2'b01) m_data = ref_load(f3, alu, word);
            else if (sel == 2'b10) m_data = pc4;
            else m_data = alu;
            m_dc = 0;
            if (valid && !mi) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"}, 32'(wb_we), 32'(m_we));
        chk({tag, ".mis"}, 32'(wb_mis), 32'(m_mis));
        chk({tag, ".cnt"}, wb_cnt, m_cnt);
        if (!m_dc) begin
            chk({tag, ".rd"}, 32'(wb_rd), 32'(m_rd));
            chk({tag, ".data"}, wb_data, m_data);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] r,
                         input logic [1:0] s, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] p,
                         input logic [31:0] w);
        valid = v; rwe = we; rd = r; sel = s; f3 = c;
        alu = a; pc4 = p; word = w;
        stall = 0; flush = 0;
    endtask

    logic [31:0] lb_exp [4];
    logic [31:0] hold_data;
    logic [31:0] hold_cnt;
    logic [4:0]  hold_rd;
    logic        hold_we;

    initial begin
        lb_exp[0] = 32'h00000001;
        lb_exp[1] = 32'h0000007F;
        lb_exp[2] = 32'hFFFFFFFF;
        lb_exp[3] = 32'hFFFFFF80;

        reset_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst.we", 32'(wb_we), 0);
        chk("rst.rd", 32'(wb_rd), 0);
        chk("rst.data", wb_data, 0);
        chk("rst.mis", 32'(wb_mis), 0);
        chk("rst.cnt", wb_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5, 2'b01, 3'b000, 32'h100 + i, 0, 32'h80FF7F01);
            step("lb");
            chk($sformatf("lb_off%0d", i), wb_data, lb_exp[i]);
        end
        drive(1, 1, 5, 2'b01, 3'b100, 32'h103, 0, 32'h80FF7F01);
        step("lbu");
        chk("lbu_off3", wb_data, 32'h00000080);

        drive(1, 1, 6, 2'b01, 3'b001, 32'h202, 0, 32'h80011234);
        step("lh");
        chk("lh_off2", wb_data, 32'hFFFF8001);
        drive(1, 1, 6, 2'b01, 3'b101, 32'h202, 0, 32'h80011234);
        step("lhu");
        chk("lhu_off2", wb_data, 32'h00008001);

        hold_cnt = wb_cnt;
        drive(1, 1, 7, 2'b01, 3'b010, 32'h301, 0, 32'hDEADBEEF);
        step("lw_mis");
        chk("lw_mis.flag", 32'(wb_mis), 1);
        chk("lw_mis.we", 32'(wb_we), 0);
        chk("lw_mis.cnt", wb_cnt, hold_cnt);

        drive(1, 1, 1, 2'b10, 3'b000, 32'h55, 32'h104, 0);
        step("pc4");
        chk("pc4.data", wb_data, 32'h104);
        chk("pc4.we", 32'(wb_we), 1);

        hold_cnt = wb_cnt;
        drive(1, 1, 0, 2'b00, 3'b000, 32'h77, 0, 0);
        step("rd0");
        chk("rd0.we", 32'(wb_we), 0);
        chk("rd0.cnt", wb_cnt, hold_cnt + 1);

        drive(1, 1, 9, 2'b00, 3'b000, 32'hCAFE0001, 0, 0);
        step("pre_stall");
        hold_data = wb_data; hold_rd = wb_rd;
        hold_we = wb_we; hold_cnt = wb_cnt;
        drive(1, 1, 10, 2'b00, 3'b000, 32'h12345678, 0, 0);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step("stall");
            chk("stall.data", wb_data, hold_data);
            chk("stall.rd", 32'(wb_rd), 32'(hold_rd));
            chk("stall.we", 32'(wb_we), 32'(hold_we));
            chk("stall.cnt", wb_cnt, hold_cnt);
        end
        flush = 1;
        step("flush_stall");
        chk("flush_stall.we", 32'(wb_we), 0);
        chk("flush_stall.cnt", wb_cnt, hold_cnt);

        drive(1, 1, 3, 2'b00, 3'b000, 32'hABCD, 0, 0);
        step("pre_rst");
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("arst.we", 32'(wb_we), 0);
        chk("arst.rd", 32'(wb_rd), 0);
        chk("arst.data", wb_data, 0);
        chk("arst.mis", 32'(wb_mis), 0);
        chk("arst.cnt", wb_cnt, 0);
        @(negedge clk);
        reset_n = 1;
        drive(1, 1, 4, 2'b00, 3'b000, 32'h4444, 0, 0);
        step("post_rst");
        chk("post_rst.cnt", wb_cnt, 1);

        force dut.instret = 32'hFFFFFFFF;
        #1;
        release dut.instret;
        m_cnt = 32'hFFFFFFFF;
        drive(1, 1, 2, 2'b00, 3'b000, 32'h1, 0, 0);
        step("wrap");
        chk("wrap.cnt", wb_cnt, 0);

        for (int n = 0; n < 400; n++) begin
            valid = ($urandom_range(0, 3) != 0);
            rwe   = $urandom_range(0, 1);
            rd    = 5'($urandom_range(0, 31));
            sel   = 2'($urandom_range(0, 3));
            f3    = 3'($urandom_range(0, 7));
            alu   = $urandom;
            pc4   = $urandom;
            word  = $urandom;
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
